mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-memory access unit at the MEM stage.
- Consumes the memory control signals produced by decode: memwrite, memtoreg, lwhb, swhb, lunsigned.
- Executes each access as a valid/ready transaction on the data-memory bus: byte-lane enables, store-data replication, load extraction with sign/zero extension.
- Stalls the pipeline until the access completes, is rejected as misaligned, or times out.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32, the byte-lane logic assumes 4 lanes.
- TIMEOUT_CYCLES, 16, maximum cycles waited in REQ or RESP before aborting; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous active-low reset.
- req_valid  input  1  MEM-stage access request.
- memwrite  input  1  store request; takes priority over memtoreg.
- memtoreg  input  1  load request.
- lwhb  input  2  load width: 11 word, 10 half, 01 byte, 00 none.
- swhb  input  2  store width, same encoding as lwhb.
- lunsigned  input  1  zero-extend loads when 1.
- addr  input  AW  byte address.
- wdata  input  DW  store data, right-aligned.
- stall  output  1  holds the pipeline.
- done  output  1  one-cycle completion pulse.
- rdata  output  DW  extended load result; valid while done=1.
- misalign  output  1  with done: access rejected as misaligned.
- bus_err  output  1  with done: access timed out.
- bus_req  output  1  bus request.
- bus_we  output  1  bus write.
- bus_addr  output  AW  word-aligned address, {addr[AW-1:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  DW  lane-replicated store data.
- bus_ready  input  1  bus accepts the request.
- bus_rvalid  input  1  read data valid.
- bus_rdata  input  DW  read word.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; done, misalign, bus_err, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata = 0; timeout counter = 0. Reset mid-transaction abandons it; no done pulse.
- Access kind: memwrite=1 means a store using swhb; else memtoreg=1 means a load using lwhb; else no access.
- States: IDLE, REQ, RESP, DONE. All outputs are registered except stall.
- IDLE, req_valid=1 and width code 00 or no access: go to DONE with no bus activity.
- IDLE, req_valid=1 and misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with misalign=1 and no bus_req.
- IDLE, req_valid=1, otherwise: latch the request, drive bus_req=1, bus_we, bus_addr, bus_be, bus_wdata; go to REQ.
- REQ: hold all bus outputs stable until bus_ready=1 (sampled on the clock edge).
  - On the handshake, bus_req goes to 0.
  - Store: go to DONE.
  - Load: go to RESP.
- RESP: on bus_rvalid=1, capture the extracted/extended bus_rdata into rdata; go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE. A new request may be accepted on the following cycle. req_valid is ignored in DONE.
- stall = (IDLE & req_valid) | REQ | RESP. It is 0 in DONE.
- Timeout: the counter clears on entry to REQ and to RESP and increments each cycle in those states.
  - When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without the awaited handshake: go to DONE with bus_err=1, rdata=0, bus_req=0.
  - A handshake arriving in that same cycle takes priority over the timeout.
- Byte enables:
  - Word: 1111.
  - Half: addr[1] ? 1100 : 0011.
  - Byte: 0001 << addr[1:0].
  - Loads drive the same bus_be.
- Store data: word = wdata; half = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
- Load extraction:
  - Byte = bus_rdata >> (8*addr[1:0]), low 8 bits.
  - Half = bus_rdata >> (16*addr[1]), low 16 bits.
  - Sign-extend, or zero-extend when lunsigned=1.
  - Word loads pass through; lunsigned is ignored for words.
- misalign and bus_err are 0 whenever done=0, and are never both 1.

Test Plan:
- Store word: addr=0x100, wdata=0xDEADBEEF, swhb=11, bus_ready 2 cycles late -> bus_be=1111, bus_addr=0x100, bus_req held 2 extra cycles, one done pulse, stall low in DONE.
- Signed byte load: addr=0x203, lwhb=01, lunsigned=0, bus_rdata=0x80123456 -> bus_be=1000, rdata=0xFFFFFF80.
- Unsigned half load: addr=0x202, lwhb=10, lunsigned=1, bus_rdata=0x8001ABCD -> bus_be=1100, rdata=0x00008001. Repeat with lunsigned=0 -> rdata=0xFFFF8001.
- Misaligned and no-op accesses:
  - Store half at addr=0x301 -> no bus_req, done=1 with misalign=1 one cycle after request.
  - Load word at 0x302 -> same response.
  - swhb=00 with memwrite=1 -> done, no bus_req, misalign=0.
- Timeout and late handshake (TIMEOUT_CYCLES=4):
  - Load with bus_ready tied 0 -> done with bus_err=1, rdata=0, bus_req dropped.
  - bus_ready arriving in the final cycle -> normal completion, bus_err=0.
- Reset mid-RESP: reset=0 while awaiting bus_rvalid -> all outputs 0 immediately, no done pulse. After release, a byte store at 0x2 completes with bus_be=0100 and bus_wdata=byte replicated.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Turns the decoded memory controls into one valid/ready bus transaction.
// It generates the byte-lane enables and replicates store data across the
// lanes. For loads it extracts the addressed byte or half and sign- or
// zero-extends it. The pipeline stalls until the access completes, is
// rejected as misaligned, or times out.
module mem_access_unit #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          memwrite,
  input  logic          memtoreg,
  input  logic [1:0]    lwhb,
  input  logic [1:0]    swhb,
  input  logic          lunsigned,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          misalign,
  output logic          bus_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ready,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_BYTE = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    width_q, width_d;
  logic [1:0]    off_q, off_d;
  logic          uns_q, uns_d;

  // Lane enables for a width code and byte offset.
  function automatic logic [3:0] lane_be(input logic [1:0] w, input logic [1:0] off);
    logic [3:0] be;
    case (w)
      W_WORD:  be = 4'b1111;
      W_HALF:  be = off[1] ? 4'b1100 : 4'b0011;
      W_BYTE:  be = 4'b0001 << off;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicates right-aligned store data onto every lane it may land on.
  function automatic logic [31:0] store_rep(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    case (w)
      W_HALF:  r = {2{d[15:0]}};
      W_BYTE:  r = {4{d[7:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pulls the addressed byte/half out of the read word and extends it.
  function automatic logic [31:0] load_ext(input logic [1:0] w, input logic [1:0] off,
                                           input logic uns, input logic [31:0] rd);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] r;
    sh_b = rd >> {off, 3'b000};
    sh_h = rd >> {off[1], 4'b0000};
    case (w)
      W_BYTE:  r = {{24{~uns & sh_b[7]}}, sh_b[7:0]};
      W_HALF:  r = {{16{~uns & sh_h[15]}}, sh_h[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  logic       is_store, is_load;
  logic [1:0] req_w;
  logic       req_misal;
  logic       to_hit;

  assign is_store  = memwrite;
  assign is_load   = ~memwrite & memtoreg;
  assign req_w     = memwrite ? swhb : lwhb;
  assign req_misal = ((req_w == W_HALF) && addr[0]) ||
                     ((req_w == W_WORD) && (addr[1:0] != 2'b00));
  assign to_hit    = TO_EN && (cnt_q == TO_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    misalign_d  = misalign_q;
    bus_err_d   = bus_err_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    width_d     = width_q;
    off_d       = off_q;
    uns_d       = uns_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          if ((!is_store && !is_load) || (req_w == W_NONE)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (req_misal) begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            width_d     = req_w;
            off_d       = addr[1:0];
            uns_d       = lunsigned;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {addr[AW-1:2], 2'b00};
            bus_be_d    = lane_be(req_w, addr[1:0]);
            bus_wdata_d = is_store ? store_rep(req_w, wdata) : '0;
          end
        end
      end
      REQ: begin
        if (bus_ready) begin
          bus_req_d = 1'b0;
          if (bus_we_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end else if (to_hit) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          bus_req_d = 1'b0;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = load_ext(width_q, off_q, uns_q, bus_rdata);
        end else if (to_hit) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      width_q     <= W_NONE;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      width_q     <= width_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
    end
  end

  assign stall     = ((state_q == IDLE) && req_valid) || (state_q == REQ) || (state_q == RESP);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
